ula_controle_multiciclo: RTL
============================

// Module: ula_controle_multiciclo
// PURPOSE
//  Next-generation ALU control unit: decodes ULAOp + funct into an ALU control code and a JR flag.
//  Outputs are registered with a valid handshake.
//  Adds multi-cycle sequencing for MULT/DIV: asserts busy and stalls new requests until a
//  cycle counter expires.
//  Sits between the main control/decode stage and the ULA datapath.
// PARAMETERS
//  FUNCT_W     6  width of funct field (>=6; only bits [5:0] decoded, upper bits must be 0)
//  CTRL_W      4  width of ula_ctrl output (>=4)
//  MUL_CYCLES  4  cycles busy is held for MULT (>=1)
//  DIV_CYCLES  8  cycles busy is held for DIV (>=1)
// PORTS
//  clock     in   1        rising-edge clock
//  reset_n   in   1        synchronous reset, active low
//  valid_in  in   1        request present on ula_op/funct
//  ula_op    in   2        ULAOp from main control
//  funct     in   FUNCT_W  instruction funct field
//  in_ready  out  1        request accepted when valid_in & in_ready
//  ctrl_vld  out  1        one-cycle pulse: ula_ctrl/jr/illegal updated
//  ula_ctrl  out  CTRL_W   ALU control code (held between requests)
//  jr        out  1        registered JR detect (ula_op=00, funct=001000)
//  illegal   out  1        R-type funct not in decode table
//  busy      out  1        multi-cycle op in progress
//  mc_done   out  1        one-cycle pulse on last busy cycle
// BEHAVIOUR
//  Reset (reset_n=0 at edge): state=IDLE, cnt=0.
//    All outputs 0 except in_ready=1.
//    Aborts any op in flight; no mc_done is issued.
//  Decode (zero-extended into CTRL_W):
//    ula_op 11 -> 0000 (ADD)
//    ula_op 10 -> 0100 (SLT)
//    ula_op 01 -> 0001 (SUB)
//    ula_op 00 with funct:
//      100000 -> 0000 ADD | 100010 -> 0001 SUB | 100100 -> 0010 AND
//      100101 -> 0011 OR  | 101010 -> 0100 SLT | 000000 -> 0101 SLL
//      011000 -> 0110 MULT (multi-cycle) | 011010 -> 0111 DIV (multi-cycle)
//      001000 -> 0000 with jr=1
//      any other funct -> 0000 with illegal=1
//  Latency: accept at edge T -> ctrl_vld=1 in cycle T+1, carrying ula_ctrl/jr/illegal.
//    jr and illegal are re-evaluated on every accept.
//  FSM IDLE:
//    in_ready=1.
//    Accept of a single-cycle op stays in IDLE.
//    Accept of MULT/DIV goes to BUSY with cnt=N-1 (N = MUL_CYCLES or DIV_CYCLES).
//  FSM BUSY:
//    busy=1 for exactly N cycles (T+1..T+N); cnt decrements each cycle.
//    mc_done=1 when cnt==0 (cycle T+N); next state is IDLE.
//    in_ready = mc_done, so a back-to-back accept is allowed in the cycle T+N.
//    An accept in that cycle acts as an accept from IDLE (may re-enter BUSY with a fresh cnt).
//  N=1: busy and mc_done are both high in cycle T+1, coincident with ctrl_vld.
//  valid_in while in_ready=0 is ignored; the requester must hold it.
//  No request is dropped once accepted, except on reset.
//  ula_ctrl holds its last value while valid_in=0.
//  cnt width = $clog2(max(MUL_CYCLES,DIV_CYCLES))+1; no wrap: reload occurs only from IDLE/accept.
// STRUCTURE
//  Shared package ula_pkg:
//    ULAOp localparams
//    funct code localparams (F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_SLL, F_MULT, F_DIV, F_JR)
//    ALU control code localparams (ULA_ADD ... ULA_DIV)
//    FSM state encoding (IDLE, BUSY)
//  One combinational sub-module, ula_decod_funct: {ula_op, funct[5:0]} -> {code, is_mc, jr, illegal}.
//  The top level holds the output registers, the FSM and the counter.
// TESTING
//  1. Reset: hold reset_n=0 for 2 cycles -> in_ready=1, all other outputs 0.
//  2. Single-cycle: valid_in=1, ula_op=00, funct=100010
//       -> next cycle ctrl_vld=1, ula_ctrl=0001, busy=0.
//     Then ula_op=11 -> ula_ctrl=0000.
//  3. JR/illegal: funct=001000 -> jr=1, ula_ctrl=0000.
//     funct=111111 -> illegal=1, jr=0.
//     ula_op=01 with funct=001000 -> jr=0.
//  4. MULT (MUL_CYCLES=4): accept at T -> busy high T+1..T+4, mc_done only at T+4.
//     A held ADD request is accepted at T+4 -> ctrl_vld at T+5.
//  5. DIV then DIV back-to-back (DIV_CYCLES=8): 16 busy cycles, 2 mc_done pulses, no idle gap.
//  6. Reset mid-op: reset at T+3 of DIV -> busy=0, no mc_done, in_ready=1 next cycle.

Source files
------------

// File: rtl/ula_controle_multiciclo_pkg.sv
// Shared encodings for the ULA control unit: ULAOp values, funct fields,
// ALU control codes, the decoder result record and the sequencer states.
package ula_pkg;

  localparam logic [1:0] OP_RTYPE = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_SLT   = 2'b10;
  localparam logic [1:0] OP_ADD   = 2'b11;

  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_MULT = 6'b011000;
  localparam logic [5:0] F_DIV  = 6'b011010;
  localparam logic [5:0] F_JR   = 6'b001000;

  localparam int CODE_W = 4;

  localparam logic [CODE_W-1:0] ULA_ADD  = 4'd0;
  localparam logic [CODE_W-1:0] ULA_SUB  = 4'd1;
  localparam logic [CODE_W-1:0] ULA_AND  = 4'd2;
  localparam logic [CODE_W-1:0] ULA_OR   = 4'd3;
  localparam logic [CODE_W-1:0] ULA_SLT  = 4'd4;
  localparam logic [CODE_W-1:0] ULA_SLL  = 4'd5;
  localparam logic [CODE_W-1:0] ULA_MULT = 4'd6;
  localparam logic [CODE_W-1:0] ULA_DIV  = 4'd7;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic              is_mc;
    logic              jr;
    logic              illegal;
  } decod_t;

endpackage

// File: rtl/ula_controle_multiciclo_if.sv
// Request/response bundle between the decode stage (master) and the ULA
// control unit (slave).
interface ula_controle_multiciclo_if #(
  parameter int FUNCT_W = 6,
  parameter int CTRL_W  = 4
);

  logic               valid_in;
  logic [1:0]         ula_op;
  logic [FUNCT_W-1:0] funct;
  logic               in_ready;
  logic               ctrl_vld;
  logic [CTRL_W-1:0]  ula_ctrl;
  logic               jr;
  logic               illegal;
  logic               busy;
  logic               mc_done;

  modport master (
    output valid_in, ula_op, funct,
    input  in_ready, ctrl_vld, ula_ctrl, jr, illegal, busy, mc_done
  );

  modport slave (
    input  valid_in, ula_op, funct,
    output in_ready, ctrl_vld, ula_ctrl, jr, illegal, busy, mc_done
  );

endinterface

// File: rtl/ula_controle_multiciclo_decod_funct.sv
// Pure combinational decode of {ula_op, funct} into ALU code, multi-cycle
// flag, JR detect and illegal-funct flag.
module ula_decod_funct
  import ula_pkg::*;
(
  input  logic [1:0] ula_op,
  input  logic [5:0] funct,
  output decod_t     dec
);

  always_comb begin
    // NOTE: every field gets a default before the case so no path can infer a latch.
    dec = '{code: ULA_ADD, is_mc: 1'b0, jr: 1'b0, illegal: 1'b0};
    case (ula_op)
      OP_ADD: dec.code = ULA_ADD;
      OP_SLT: dec.code = ULA_SLT;
      OP_SUB: dec.code = ULA_SUB;
      default: begin
        case (funct)
          F_ADD:  dec.code = ULA_ADD;
          F_SUB:  dec.code = ULA_SUB;
          F_AND:  dec.code = ULA_AND;
          F_OR:   dec.code = ULA_OR;
          F_SLT:  dec.code = ULA_SLT;
          F_SLL:  dec.code = ULA_SLL;
          F_MULT: begin
            dec.code  = ULA_MULT;
            dec.is_mc = 1'b1;
          end
          F_DIV: begin
            dec.code  = ULA_DIV;
            dec.is_mc = 1'b1;
          end
          F_JR:    dec.jr      = 1'b1;
          default: dec.illegal = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/ula_controle_multiciclo.sv
// ULA control unit: registered decode with a valid pulse, plus a busy
// sequencer that stalls new requests while MULT/DIV run.
module ula_controle_multiciclo
  import ula_pkg::*;
#(
  parameter int FUNCT_W    = 6,
  parameter int CTRL_W     = 4,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 8
) (
  input logic                      clock,
  input logic                      reset_n,
  ula_controle_multiciclo_if.slave bus
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  if (FUNCT_W < 6 || CTRL_W < CODE_W || MUL_CYCLES < 1 || DIV_CYCLES < 1) begin : g_param_check
    $error("ula_controle_multiciclo: unsupported parameter set");
  end

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic              accept, ready, done;
  decod_t            dec;
  logic              ctrl_vld_q;
  logic [CTRL_W-1:0] ula_ctrl_q;
  logic              jr_q, illegal_q;

  ula_decod_funct u_decod (
    .ula_op (bus.ula_op),
    .funct  (bus.funct[5:0]),
    .dec    (dec)
  );

  // The last busy cycle doubles as an IDLE cycle, so an accept there reloads directly.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    ready      = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: ready = 1'b1;
      BUSY: begin
        if (cnt == '0) begin
          done       = 1'b1;
          ready      = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
    endcase
    accept = bus.valid_in & ready;
    if (accept && dec.is_mc) begin
      state_next = BUSY;
      cnt_next   = (dec.code == ULA_DIV) ? DIV_LOAD : MUL_LOAD;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      ctrl_vld_q <= 1'b0;
      ula_ctrl_q <= '0;
      jr_q       <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      ctrl_vld_q <= accept;
      if (accept) begin
        ula_ctrl_q <= CTRL_W'(dec.code);
        jr_q       <= dec.jr;
        illegal_q  <= dec.illegal;
      end
    end
  end

  assign bus.in_ready = ready;
  assign bus.ctrl_vld = ctrl_vld_q;
  assign bus.ula_ctrl = ula_ctrl_q;
  assign bus.jr       = jr_q;
  assign bus.illegal  = illegal_q;
  assign bus.busy     = (state == BUSY);
  assign bus.mc_done  = done;

endmodule
